// File: rtl/flag_mult_if.sv
// Strobe-path bundle for flag_mult: request strobe in, pulse train and status out.
// pi_flag is a one-cycle strobe with no ready: the slave always takes it and either
// starts a burst, queues it, or rejects it (reported a cycle later on drop).
interface flag_mult_if #(
  parameter int PEND_W = 2
);
  logic              pi_flag;
  logic              po_flag;
  logic              busy;
  logic              drop;
  logic [PEND_W-1:0] pend;

  modport master (output pi_flag, input po_flag, busy, drop, pend);
  modport slave  (input pi_flag, output po_flag, busy, drop, pend);
endinterface

// File: rtl/flag_mult.sv
// Pulse multiplier: each request becomes MULT single-cycle pulses GAP cycles apart.
// FLAG_MULT_QUEUE_EN enables the pending-request queue; undefined drops all requests while busy.
module flag_mult #(
  parameter int MULT   = 4,
  parameter int GAP    = 2,
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  flag_mult_if.slave  fif,
  output logic        dbg_state
);
  localparam int GW = (GAP  > 1) ? $clog2(GAP)  : 1;
  localparam int MW = (MULT > 1) ? $clog2(MULT) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
  localparam logic [MW-1:0] MULT_LAST = MW'(MULT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic [MW-1:0]   pulse_cnt, pulse_n;
  logic            po_q, drop_q, drop_n;
  logic            last;

`ifdef FLAG_MULT_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  logic [PEND_W-1:0] pend_q, pend_n;
`endif

  assign last = (state == RUN) && (gap_cnt == GAP_LAST) && (pulse_cnt == MULT_LAST);

  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    pulse_n = pulse_cnt;
    drop_n  = 1'b0;
`ifdef FLAG_MULT_QUEUE_EN
    pend_n  = pend_q;
`endif
    case (state)
      IDLE: begin
        if (fif.pi_flag) begin
          state_n = RUN;
          gap_n   = '0;
          pulse_n = '0;
        end
      end
      RUN: begin
        if (last) begin
          gap_n   = '0;
          pulse_n = '0;
`ifdef FLAG_MULT_QUEUE_EN
          // A request arriving on the last cycle starts the next window itself,
          // so a queued entry is consumed only when no new request shows up.
          if (fif.pi_flag || (pend_q != '0)) begin
            if (!fif.pi_flag) pend_n = pend_q - 1'b1;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = IDLE;
          drop_n  = fif.pi_flag;
`endif
        end else begin
          if (gap_cnt == GAP_LAST) begin
            gap_n   = '0;
            pulse_n = pulse_cnt + 1'b1;
          end else begin
            gap_n   = gap_cnt + 1'b1;
          end
`ifdef FLAG_MULT_QUEUE_EN
          if (fif.pi_flag) begin
            if (pend_q != PEND_MAX) pend_n = pend_q + 1'b1;
            else                    drop_n = 1'b1;
          end
`else
          drop_n = fif.pi_flag;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      pulse_cnt <= '0;
      po_q      <= 1'b0;
      drop_q    <= 1'b0;
`ifdef FLAG_MULT_QUEUE_EN
      pend_q    <= '0;
`endif
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_n;
      pulse_cnt <= pulse_n;
      po_q      <= (state_n == RUN) && (gap_n == '0);
      drop_q    <= drop_n;
`ifdef FLAG_MULT_QUEUE_EN
      pend_q    <= pend_n;
`endif
    end
  end

  assign fif.po_flag = po_q;
  assign fif.busy    = (state == RUN);
  assign fif.drop    = drop_q;
  assign dbg_state   = (state == RUN);
`ifdef FLAG_MULT_QUEUE_EN
  assign fif.pend    = pend_q;
`else
  assign fif.pend    = '0;
`endif
endmodule

// File: tb/tb_flag_mult.sv
// Bench for flag_mult: directed timeline table, degenerate MULT=1/GAP=1 case, random vs model.
module tb_flag_mult;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flag_mult_if #(.PEND_W(PW)) f0 ();
  flag_mult_if #(.PEND_W(PW)) f1 ();
  logic dbg0, dbg1;

  flag_mult #(.MULT(4), .GAP(2), .PEND_W(PW)) dut0 (.clk(clk), .rst(rst), .fif(f0), .dbg_state(dbg0));
  flag_mult #(.MULT(1), .GAP(1), .PEND_W(PW)) dut1 (.clk(clk), .rst(rst), .fif(f1), .dbg_state(dbg1));

`ifdef FLAG_MULT_QUEUE_EN
  bit qen = 1'b1;
`else
  bit qen = 1'b0;
`endif

  int vec  = 0;
  int errs = 0;

  // Behavioural model: a window is an offset 0..MULT*GAP-1; pulses where offset % GAP == 0.
  int m_mult [2] = '{4, 1};
  int m_gap  [2] = '{2, 1};
  bit m_act  [2];
  int m_off  [2];
  int m_pend [2];
  bit m_drop [2];

  task automatic model_step(int i, bit pi, bit r);
    int  pmax;
    bit  lst;
    pmax = (1 << PW) - 1;
    if (r) begin
      m_act[i] = 0; m_off[i] = 0; m_pend[i] = 0; m_drop[i] = 0;
      return;
    end
    m_drop[i] = 0;
    if (!m_act[i]) begin
      if (pi) begin m_act[i] = 1; m_off[i] = 0; end
    end else begin
      lst = (m_off[i] == m_mult[i] * m_gap[i] - 1);
      if (lst) begin
        if (qen && (pi || m_pend[i] > 0)) begin
          m_off[i] = 0;
          if (!pi) m_pend[i]--;
        end else begin
          m_act[i] = 0; m_off[i] = 0;
          if (pi) m_drop[i] = 1;
        end
      end else begin
        m_off[i]++;
        if (pi) begin
          if (qen && m_pend[i] < pmax) m_pend[i]++;
          else m_drop[i] = 1;
        end
      end
    end
  endtask

  task automatic check_dut(int i, int cyc);
    logic po, bz, dr, st;
    logic [PW-1:0] pd;
    logic e_po;
    if (i == 0) begin po = f0.po_flag; bz = f0.busy; dr = f0.drop; pd = f0.pend; st = dbg0; end
    else        begin po = f1.po_flag; bz = f1.busy; dr = f1.drop; pd = f1.pend; st = dbg1; end
    e_po = m_act[i] && (m_off[i] % m_gap[i] == 0);
    vec++;
    if (po !== e_po || bz !== m_act[i] || dr !== m_drop[i] || st !== m_act[i] ||
        int'(pd) != m_pend[i]) begin
      errs++;
      $display("FAIL model dut%0d cyc %0d: po/busy/drop/state got %b%b%b%b pend %0d, exp %b%b%b%b pend %0d",
               i, cyc, po, bz, dr, st, pd, e_po, m_act[i], m_drop[i], m_act[i], m_pend[i]);
    end
  endtask

  task automatic expect_bit(string nm, int cyc, logic got, logic exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc %0d: got %b exp %b", nm, cyc, got, exp);
    end
  endtask

  int tcyc = 0;
  task automatic step(bit p0, bit p1, bit r);
    @(negedge clk);
    f0.pi_flag = p0;
    f1.pi_flag = p1;
    rst        = r;
    @(posedge clk);
    model_step(0, p0, r);
    model_step(1, p1, r);
    #1;
    tcyc++;
    check_dut(0, tcyc);
    check_dut(1, tcyc);
  endtask

  typedef struct {
    string       nm;
    logic [47:0] pi, rs, po, busy, drop, pnz;
  } row_t;
  row_t rows [4];

  function automatic logic [47:0] rng(int a, int b, int s);
    logic [47:0] m;
    m = '0;
    for (int k = a; k <= b; k += s) m[k] = 1'b1;
    return m;
  endfunction

  function automatic row_t mk(string nm, logic [47:0] pi, logic [47:0] rs, logic [47:0] po,
                              logic [47:0] busy, logic [47:0] drop, logic [47:0] pnz);
    row_t r;
    r.nm = nm; r.pi = pi; r.rs = rs; r.po = po; r.busy = busy; r.drop = drop; r.pnz = pnz;
    return r;
  endfunction

  initial begin
    f0.pi_flag = 1'b0;
    f1.pi_flag = 1'b0;
    rst = 1'b1;

    // Bit k of each mask is spec cycle k (pi driven in k, outputs observed in k).
    rows[0] = mk("single", rng(10, 10, 1), '0, rng(11, 17, 2), rng(11, 18, 1), '0, '0);
`ifdef FLAG_MULT_QUEUE_EN
    rows[1] = mk("queued", rng(10, 12, 2), '0, rng(11, 25, 2), rng(11, 26, 1), '0, rng(13, 18, 1));
    rows[2] = mk("overflow", rng(10, 10, 1) | rng(12, 15, 1), '0, rng(11, 41, 2), rng(11, 42, 1),
                 rng(16, 16, 1), rng(13, 34, 1));
`else
    rows[1] = mk("drop", rng(10, 12, 2), '0, rng(11, 17, 2), rng(11, 18, 1), rng(13, 13, 1), '0);
    rows[2] = mk("overflow", rng(10, 10, 1) | rng(12, 15, 1), '0, rng(11, 17, 2), rng(11, 18, 1),
                 rng(13, 16, 1), '0);
`endif
    rows[3] = mk("reset_mid", rng(10, 20, 10), rng(14, 14, 1), rng(11, 13, 2) | rng(21, 27, 2),
                 rng(11, 14, 1) | rng(21, 28, 1), '0, '0);

    step(0, 0, 1);
    step(0, 0, 1);
    expect_bit("reset_po",   tcyc, f0.po_flag, 1'b0);
    expect_bit("reset_busy", tcyc, f0.busy,    1'b0);
    expect_bit("reset_drop", tcyc, f0.drop,    1'b0);
    expect_bit("reset_pend", tcyc, f0.pend != '0, 1'b0);
    expect_bit("reset_state", tcyc, dbg0,      1'b0);

    for (int r = 0; r < 4; r++) begin
      step(0, 0, 1);
      step(0, 0, 1);
      for (int c = 0; c < 46; c++) begin
        step(rows[r].pi[c], 1'b0, rows[r].rs[c]);
        expect_bit({rows[r].nm, "_po"},   c + 1, f0.po_flag,    rows[r].po[c+1]);
        expect_bit({rows[r].nm, "_busy"}, c + 1, f0.busy,       rows[r].busy[c+1]);
        expect_bit({rows[r].nm, "_drop"}, c + 1, f0.drop,       rows[r].drop[c+1]);
        expect_bit({rows[r].nm, "_pend"}, c + 1, f0.pend != '0, rows[r].pnz[c+1]);
`ifdef FLAG_MULT_QUEUE_EN
        if (r == 2 && c >= 12 && c <= 14)
          expect_bit("overflow_pend_val", c + 1, f0.pend == PW'(c - 11), 1'b1);
`endif
      end
    end

    // Degenerate MULT=1, GAP=1: a held request yields a continuous pulse train.
    step(0, 0, 1);
    step(0, 0, 1);
    for (int c = 0; c < 24; c++) begin
      step(1'b0, (c >= 10 && c <= 19), 1'b0);
`ifdef FLAG_MULT_QUEUE_EN
      expect_bit("degen_po",   c + 1, f1.po_flag,    (c + 1 >= 11 && c + 1 <= 20));
      expect_bit("degen_busy", c + 1, f1.busy,       (c + 1 >= 11 && c + 1 <= 20));
      expect_bit("degen_drop", c + 1, f1.drop,       1'b0);
      expect_bit("degen_pend", c + 1, f1.pend != '0, 1'b0);
`endif
    end

    // Random traffic on both instances, checked every cycle against the model.
    step(0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/flag_mult.md
# flag_mult

Pulse multiplier: expands each single-cycle input flag into a burst of MULT evenly spaced single-cycle output flags, GAP cycles apart. It is the expanding counterpart of the flag divide-by-4 stage and sits in the same clk domain on the same strobe path. It regenerates a faster strobe train from a decimated one. Input flags that arrive during a burst are queued or dropped, depending on configuration.

## Interface
- MULT, default 4: output pulses per input flag; ≥1.
- GAP, default 2: cycles between successive output pulses; ≥1. GAP=1 gives consecutive pulses.
- PEND_W, default 2: width of the pending-request counter; max queued requests = 2^PEND_W−1.
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- pi_flag  in  1  single-cycle request strobe; may be high on any cycle, including consecutive cycles.
- po_flag  out  1  registered output pulse train.
- busy  out  1  high for every cycle of an active burst window.
- drop  out  1  registered one-cycle pulse, the cycle after a rejected pi_flag.
- pend  out  PEND_W  number of queued requests not yet started.

## Operation
- **Burst window:** MULT*GAP cycles long. po_flag=1 at window offsets 0, GAP, 2·GAP … (MULT−1)·GAP, and 0 at all other offsets. busy=1 for the whole window.
- **States:**
  - IDLE (busy=0).
  - RUN (inside a window). Tracked by a gap counter (0..GAP−1) and a pulse counter (0..MULT−1).
- **IDLE → RUN:** pi_flag=1 in IDLE. The window starts the next cycle.
- **RUN, not last window cycle:** advance the counters.
- **RUN, last window cycle:**
  - If pend>0 (or, with the queue enabled, pi_flag=1 this cycle), start a new window the next cycle and decrement pend if it was used.
  - Otherwise go to IDLE.
- **pi_flag while busy=1:**
  - Queue enabled: if pend<max, pend+1; otherwise drop.
  - Queue disabled: always drop.
- **Simultaneous pi_flag and window-end dequeue:** pend is unchanged, net zero. If pend==max, there is no drop, because the dequeue frees a slot.
- **pi_flag on the last window cycle with pend==0 and the queue enabled:** the request starts the next window directly; pend stays 0.
- **Counter sizing:** counters are sized with $clog2 of their range. With MULT=1 or GAP=1 the degenerate counter is held at 0. Counters must not wrap outside their range.

## Timing
- Reset values: po_flag=0, busy=0, drop=0, pend=0, state IDLE, counters 0.
- Latency: pi_flag in IDLE at cycle t gives po_flag at t+1, t+1+GAP, …; busy is high from t+1 through t+MULT·GAP.
- Queued bursts are seamless. The next window starts the cycle after the previous window ends, so pulse spacing stays uniform at GAP across bursts.
- A pi_flag in the first IDLE cycle after a window starts a new window the following cycle. That is one idle cycle of extra spacing, which is accepted.
- drop and pend updates are visible one cycle after the causing pi_flag.
- rst mid-burst: all outputs are 0 from the next cycle. A pi_flag coincident with rst is ignored. The queue is flushed.

## Configuration
- Macro: FLAG_MULT_QUEUE_EN.
- **Defined:** pending counter active; requests during busy are queued up to 2^PEND_W−1 and the excess is dropped.
- **Undefined:** no queue. pend is tied to 0, every pi_flag while busy=1 pulses drop, and the last-cycle chaining rule does not apply.

## Test plan
All scenarios use MULT=4, GAP=2 unless noted.
- **Single request:** pi_flag at cycle 10 → po_flag at 11, 13, 15, 17; busy 11–18; drop never asserted; pend stays 0.
- **Queued request (macro on):** pi_flag at 10 and 12 → pend=1 from 13; second burst po_flag at 19, 21, 23, 25; busy continuous 11–26; pend=0 from 19.
- **Drop, no queue (macro off):** pi_flag at 10 and 12 → only pulses at 11, 13, 15, 17; drop=1 at 13 only.
- **Queue overflow (PEND_W=2, macro on):** pi_flag at 10, 12, 13, 14, 15 → pend 1, 2, 3 at 13, 14, 15; drop=1 at 16; exactly 3 further bursts follow the first, for 16 pulses total.
- **Reset mid-burst:** pi_flag at 10, rst=1 at 14 → po_flag pulses at 11 and 13 only; busy=0 and pend=0 from 15. A later pi_flag at 20 restarts normally with a pulse at 21.
- **Degenerate (MULT=1, GAP=1, macro on):** pi_flag held high for cycles 10–19 → po_flag high for cycles 11–20; busy 11–20; pend stays 0; no drop.
